// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared shift-mode and FSM-state encodings for shift_reg_n.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

  typedef enum logic [2:0] {
    SHR = 3'd0,
    SHL = 3'd1,
    ASR = 3'd2,
    ROR = 3'd3,
    ROL = 3'd4
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

endpackage

`default_nettype wire

// File: rtl/shift_unit.sv
// ============================================================================
// Module      : shift_unit
// Description : Combinational next-value and Shift_Out for one shift step.
//               Rotate modes are built only when SHIFT_REG_N_ROTATE_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_in,
  output logic [WIDTH-1:0] data_next,
  output logic             shift_out
);

  always_comb begin
    data_next = data_in;
    shift_out = 1'b0;
    case (mode)
      SHR: begin
        data_next = {shift_in, data_in[WIDTH-1:1]};
        shift_out = data_in[0];
      end
      SHL: begin
        data_next = {data_in[WIDTH-2:0], shift_in};
        shift_out = data_in[WIDTH-1];
      end
      ASR: begin
        data_next = {data_in[WIDTH-1], data_in[WIDTH-1:1]};
        shift_out = data_in[0];
      end
`ifdef SHIFT_REG_N_ROTATE_EN
      ROR: begin
        data_next = {data_in[0], data_in[WIDTH-1:1]};
        shift_out = data_in[0];
      end
      ROL: begin
        data_next = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
        shift_out = data_in[WIDTH-1];
      end
`endif
      // Unused encodings (and rotates when not built) hold the value.
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_reg_n.sv
// ============================================================================
// Module      : shift_reg_n
// Description : Multi-mode shift register with clear, load, single-step and
//               self-timed burst shifting. Option macro: SHIFT_REG_N_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_n
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic [2:0]       Mode,
  input  logic             Shift_In,
  input  logic             Shift_En,
  input  logic             Start,
  input  logic [CW-1:0]    Count,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Shift_Out,
  output logic             Busy,
  output logic             Done
);

  shift_state_t     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data,  w_data_nxt;
  logic [CW-1:0]    r_rem,   w_rem_nxt;
  logic [2:0]       r_mode,  w_mode_nxt;
  logic [2:0]       w_mode;
  logic [WIDTH-1:0] w_shifted;
  logic             w_shift_out;

  // A running burst follows its latched mode; otherwise the live input.
  assign w_mode = (r_state == SHIFT) ? r_mode : Mode;

  shift_unit #(
    .WIDTH (WIDTH)
  ) u_shift_unit (
    .mode      (w_mode),
    .data_in   (r_data),
    .shift_in  (Shift_In),
    .data_next (w_shifted),
    .shift_out (w_shift_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_rem_nxt   = r_rem;
    w_mode_nxt  = r_mode;
    if (Clear) begin
      w_data_nxt  = '0;
      w_state_nxt = IDLE;
    end else if (r_state == SHIFT) begin
      w_data_nxt = w_shifted;
      w_rem_nxt  = r_rem - CW'(1);
      if (r_rem == CW'(1)) begin
        w_state_nxt = DONE;
      end
    end else begin
      // IDLE and DONE behave alike; DONE always falls back after one cycle.
      w_state_nxt = IDLE;
      if (Load) begin
        w_data_nxt = D;
      end else if (Start) begin
        w_mode_nxt  = Mode;
        w_rem_nxt   = Count;
        w_state_nxt = (Count != '0) ? SHIFT : DONE;
      end else if (Shift_En) begin
        w_data_nxt = w_shifted;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_rem   <= '0;
      r_mode  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_rem   <= w_rem_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  assign Data_Out  = r_data;
  assign Shift_Out = w_shift_out;
  assign Busy      = (r_state == SHIFT);
  assign Done      = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_n.sv
// ============================================================================
// Module      : tb_shift_reg_n
// Description : Directed scoreboard bench for shift_reg_n (WIDTH = 8).
//               Expected results follow SHIFT_REG_N_ROTATE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_n;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Clear;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic [2:0]       Mode;
  logic             Shift_In;
  logic             Shift_En;
  logic             Start;
  logic [CW-1:0]    Count;
  logic [WIDTH-1:0] Data_Out;
  logic             Shift_Out;
  logic             Busy;
  logic             Done;

  int vectors   = 0;
  int errors    = 0;
  int done_seen = 0;
  logic [WIDTH-1:0] sb_q[$];

  shift_reg_n #(
    .WIDTH (WIDTH)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Clear     (Clear),
    .Load      (Load),
    .D         (D),
    .Mode      (Mode),
    .Shift_In  (Shift_In),
    .Shift_En  (Shift_En),
    .Start     (Start),
    .Count     (Count),
    .Data_Out  (Data_Out),
    .Shift_Out (Shift_Out),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: each Done pulse retires one expected burst result.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && Done === 1'b1) begin
      done_seen++;
      check("busy_with_done", 32'(Busy), 32'd0);
      vectors++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got Done=1 with data %0h expected no Done", Data_Out);
      end else begin
        logic [WIDTH-1:0] exp;
        exp = sb_q.pop_front();
        vectors--;
        check("burst_result", 32'(Data_Out), 32'(exp));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] val);
    D    = val;
    Load = 1'b1;
    tick();
    Load = 1'b0;
  endtask

  // Issues a burst; optionally checks Shift_Out follows the latched mode and
  // optionally drives Load/Shift_En during the burst (they must be ignored).
  task automatic burst(input logic [2:0] mode, input logic [CW-1:0] cnt,
                       input logic [WIDTH-1:0] exp, input bit chk_so,
                       input logic so_exp, input bit meddle);
    int n;
    Mode  = mode;
    Count = cnt;
    Start = 1'b1;
    sb_q.push_back(exp);
    tick();
    Start = 1'b0;
    Mode  = 3'd1;
    if (chk_so) check("so_latched_mode", 32'(Shift_Out), 32'(so_exp));
    if (meddle) begin
      D        = 8'h55;
      Load     = 1'b1;
      Shift_En = 1'b1;
    end
    n = 0;
    while (Busy && n < 100) begin
      n++;
      tick();
    end
    Load     = 1'b0;
    Shift_En = 1'b0;
    check("busy_cycles", 32'(n), 32'(cnt));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    Reset_n  = 1'b0;
    Clear    = 1'b0;
    Load     = 1'b0;
    D        = '0;
    Mode     = 3'd0;
    Shift_In = 1'b0;
    Shift_En = 1'b0;
    Start    = 1'b0;
    Count    = '0;
    repeat (2) @(posedge Clk);
    #3 Reset_n = 1'b1;
    tick();
    check("reset_data", 32'(Data_Out), 32'h00);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);

    // Arithmetic burst: B4 ASR x3 -> F6
    load(8'hB4);
    burst(3'd2, CW'(3), 8'hF6, 1'b1, 1'b0, 1'b0);

    // Single-step SHL with Shift_In = 1
    load(8'h0F);
    Mode     = 3'd1;
    Shift_In = 1'b1;
    check("so_before_shl", 32'(Shift_Out), 32'd0);
    Shift_En = 1'b1;
    tick();
    check("shl_step1", 32'(Data_Out), 32'h1F);
    tick();
    Shift_En = 1'b0;
    check("shl_step2", 32'(Data_Out), 32'h3F);
    Shift_In = 1'b0;

    // Rotate right by 9 (wraps past the width)
    load(8'h81);
`ifdef SHIFT_REG_N_ROTATE_EN
    burst(3'd3, CW'(9), 8'hC0, 1'b1, 1'b1, 1'b0);
    burst(3'd0, CW'(0), 8'hC0, 1'b0, 1'b0, 1'b0);
`else
    burst(3'd3, CW'(9), 8'h81, 1'b1, 1'b0, 1'b0);
    burst(3'd0, CW'(0), 8'h81, 1'b0, 1'b0, 1'b0);
`endif

    // SHR burst with Load and Shift_En ignored while busy: C3 -> FC
    load(8'hC3);
    Shift_In = 1'b1;
    burst(3'd0, CW'(4), 8'hFC, 1'b1, 1'b1, 1'b1);
    check("after_meddle", 32'(Data_Out), 32'hFC);
    Shift_In = 1'b0;

    // Clear aborts an SHR burst on its 3rd shift cycle
    load(8'hAA);
    Mode  = 3'd0;
    Count = CW'(6);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("abort_busy", 32'(Busy), 32'd1);
    tick();
    tick();
    check("abort_mid", 32'(Data_Out), 32'h2A);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("abort_data", 32'(Data_Out), 32'h00);
    check("abort_idle", 32'(Busy), 32'd0);
    Shift_In = 1'b1;
    burst(3'd1, CW'(1), 8'h01, 1'b1, 1'b0, 1'b0);
    Shift_In = 1'b0;

    // Async reset between the 2nd and 3rd shift edges of an ASR burst
    load(8'hFF);
    Mode  = 3'd2;
    Count = CW'(5);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_data", 32'(Data_Out), 32'h00);
    check("async_rst_busy", 32'(Busy), 32'd0);
    check("async_rst_done", 32'(Done), 32'd0);
    @(posedge Clk);
    #3 Reset_n = 1'b1;
    repeat (8) tick();
    check("post_rst_data", 32'(Data_Out), 32'h00);

    check("done_pulses", 32'(done_seen), 32'd5);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
